video_timing_gen: RTL
=====================

# video_timing_gen

Generates 640x480@60 raster timing for the HDMI output path, from a 25 MHz pixel clock. It drives the `h_count`/`v_count` coordinates consumed by the background/pattern generators. It registers the returned 16-bit pixel together with aligned sync and data-enable, and emits 24-bit RGB for the HDMI encoder. It is the source end of the coordinate interface: counters out, pixel data back in.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, clocks
- `H_SYNC`, 96: hsync width, clocks
- `H_BP`, 48: horizontal back porch, clocks
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, lines
- `V_SYNC`, 2: vsync width, lines
- `V_BP`, 33: vertical back porch, lines
- `SYNC_POL`, 0: sync active level (0 = active-low)

Ports:
- `clk`  in  1  pixel clock; the block's one clock
- `rst`  in  1  reset, asynchronous and active-low
- `h_count`  out  10  current x coordinate, 0..H_TOTAL-1
- `v_count`  out  10  current y coordinate, 0..V_TOTAL-1; pattern generators take bits [8:0]
- `pixel_in`  in  16  pixel for the current (`h_count`,`v_count`), format 0RGB 4:4:4 in bits [11:0]
- `hsync`  out  1  horizontal sync
- `vsync`  out  1  vertical sync
- `video_de`  out  1  data enable, high during visible pixels
- `rgb`  out  24  {R8,G8,B8}
- `frame_start`  out  1  one-clock pulse on the first visible pixel of each frame

## Operation
- Frame sizes: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both totals must be ≤ 1024.
- Stage 0 is the counter stage.
  - `h_count` increments by 1 every clock.
  - At H_TOTAL-1, `h_count` wraps to 0 and `v_count` increments.
  - At (H_TOTAL-1, V_TOTAL-1), both counters wrap to 0.
- Stage-0 decode, all combinational from the counters:
  - de0 = h < H_ACTIVE && v < V_ACTIVE
  - hs0 active for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, which is 656..751
  - vs0 active for V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, which is 490..491
  - fs0 = (h == 0 && v == 0)
- `pixel_in` is a combinational function of `h_count`/`v_count` and is sampled in the same clock as stage 0.
- Stage 1 is the output register. On each clock edge it loads:
  - `video_de` ← de0
  - `frame_start` ← fs0
  - `hsync` ← hs0 ? SYNC_POL : ~SYNC_POL
  - `vsync` ← vs0 ? SYNC_POL : ~SYNC_POL
  - `rgb` ← de0 ? expand(pixel_in) : 24'h0
- expand replicates each nibble: R8 = {p[11:8],p[11:8]}, G8 = {p[7:4],p[7:4]}, B8 = {p[3:0],p[3:0]}. Bits [15:12] are ignored.
- No handshake: the block free-runs and the downstream sink must accept every clock.

## Timing
- While `rst` is low (asynchronous):
  - `h_count` = 0, `v_count` = 0
  - `video_de` = 0, `frame_start` = 0, `rgb` = 0
  - `hsync` = `vsync` = ~SYNC_POL (inactive, i.e. 1)
- First clock edge after `rst` rises:
  - stage 1 loads the decode of (0,0): `video_de` = 1, `frame_start` = 1, `rgb` = expand(pixel for (0,0))
  - counters advance to (1,0)
- Latency:
  - `hsync`/`vsync`/`video_de`/`rgb`/`frame_start` lag `h_count`/`v_count` by exactly 1 clock
  - all five stage-1 outputs are mutually aligned
- Line wrap: `h_count` goes 799 → 0; `v_count` increments in the same edge.
- Frame wrap: at (799,524), both counters go to 0 in one edge. `frame_start` pulses exactly 1 clock later.
- Reset asserted mid-frame: all outputs return to their reset values immediately, with no clock required. Counting restarts at (0,0).
- Sync lengths:
  - `hsync` active 96 clocks per line
  - `vsync` active 2 lines = 1600 clocks, starting at stage-1 output of (0,490)
- `video_de` is high for 640 consecutive clocks per line, on lines 0..479 only. That is 307200 clocks per frame.

## Test plan
- Reset/startup:
  - hold `rst` = 0 for 5 clocks → outputs at reset values (`hsync` = `vsync` = 1, `rgb` = 0)
  - release → first edge gives `video_de` = 1, `frame_start` = 1, counters (1,0)
- Line timing: count clocks across one line:
  - `video_de` high 640, low 160
  - `hsync` low for 96 clocks, from the output of h = 656 through h = 751
  - period 800
- Frame timing over 2 full frames:
  - `frame_start` pulses every 420000 clocks
  - `vsync` low exactly 1600 clocks per frame
  - `video_de` high 307200 clocks per frame
- Pixel path: drive `pixel_in` = 16'h000F when (h[6]^v[6]) else 16'h0FFF, with 0 when h ≥ 320 or v ≥ 240:
  - at (0,0) `rgb` = 24'hFFFFFF
  - at (64,0) `rgb` = 24'h0000FF
  - at (400,10) `rgb` = 0
  - in blanking (700,10) `rgb` = 0 even if `pixel_in` = 16'hFFFF
- Nibble expansion/ignore: `pixel_in` = 16'hF5A3 at a visible pixel → `rgb` = 24'h55AA33 one clock later.
- Mid-frame reset: assert `rst` at (400,300) between edges → outputs go to reset values before the next edge. After release, the sequence matches the startup scenario.

Source files
------------

// File: rtl/video_timing_gen_if.sv
// Coordinate bus between the raster timing source and the pixel generators.
// The timing generator drives the x/y coordinates; the pattern side returns
// the 16-bit 0RGB 4:4:4 pixel for those coordinates in the same clock.
interface video_timing_gen_if;
  logic [9:0]  h_count;
  logic [9:0]  v_count;
  logic [15:0] pixel_in;

  modport master (
    output h_count,
    output v_count,
    input  pixel_in
  );

  modport slave (
    input  h_count,
    input  v_count,
    output pixel_in
  );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator (640x480@60 by default) for the HDMI output path.
// Stage 0: free-running x/y counters published on the coordinate bus, plus
// combinational decode of data-enable, syncs and frame start.
// Stage 1: output register aligning sync/DE/frame_start with the returned
// pixel, which is expanded from 4:4:4 to 24-bit RGB.
// Both totals must stay at or below 1024 to fit the 10-bit counters.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  video_timing_gen_if.master        coord,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      video_de,
  output logic [23:0]               rgb,
  output logic                      frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST_C   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST_C   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_C    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_C    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEGIN_C = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END_C   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEGIN_C = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END_C   = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Replicate each 4-bit colour component into 8 bits: {R,R},{G,G},{B,B}.
  function automatic logic [23:0] expand(input logic [11:0] p);
    expand = {p[11:8], p[11:8], p[7:4], p[7:4], p[3:0], p[3:0]};
  endfunction

  logic [9:0]  h_count_r;
  logic [9:0]  v_count_r;
  logic        de0_s;
  logic        hs0_s;
  logic        vs0_s;
  logic        fs0_s;
  logic        hsync_r;
  logic        vsync_r;
  logic        video_de_r;
  logic        frame_start_r;
  logic [23:0] rgb_r;
  logic [3:0]  pix_unused_s;

  // The top nibble of the returned pixel carries no colour information.
  assign pix_unused_s = coord.pixel_in[15:12];

  // Stage 0: x counter wraps at end of line, y steps on the wrap, both wrap at end of frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_count_r <= 10'd0;
      v_count_r <= 10'd0;
    end else if (h_count_r == H_LAST_C) begin
      h_count_r <= 10'd0;
      if (v_count_r == V_LAST_C) begin
        v_count_r <= 10'd0;
      end else begin
        v_count_r <= v_count_r + 10'd1;
      end
    end else begin
      h_count_r <= h_count_r + 10'd1;
    end
  end

  // Stage 0 decode of visible area, sync windows and frame origin from the counters.
  always_comb begin
    de0_s = 1'b0;
    hs0_s = 1'b0;
    vs0_s = 1'b0;
    fs0_s = 1'b0;
    if ((h_count_r < H_ACT_C) && (v_count_r < V_ACT_C)) begin
      de0_s = 1'b1;
    end else begin
      de0_s = 1'b0;
    end
    if ((h_count_r >= HS_BEGIN_C) && (h_count_r < HS_END_C)) begin
      hs0_s = 1'b1;
    end else begin
      hs0_s = 1'b0;
    end
    if ((v_count_r >= VS_BEGIN_C) && (v_count_r < VS_END_C)) begin
      vs0_s = 1'b1;
    end else begin
      vs0_s = 1'b0;
    end
    if ((h_count_r == 10'd0) && (v_count_r == 10'd0)) begin
      fs0_s = 1'b1;
    end else begin
      fs0_s = 1'b0;
    end
  end

  // Stage 1: register decode and pixel together so every output lags the counters by one clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      video_de_r    <= 1'b0;
      frame_start_r <= 1'b0;
      hsync_r       <= ~SYNC_POL;
      vsync_r       <= ~SYNC_POL;
      rgb_r         <= 24'h000000;
    end else begin
      video_de_r    <= de0_s;
      frame_start_r <= fs0_s;
      hsync_r       <= hs0_s ? SYNC_POL : ~SYNC_POL;
      vsync_r       <= vs0_s ? SYNC_POL : ~SYNC_POL;
      rgb_r         <= de0_s ? expand(coord.pixel_in[11:0]) : 24'h000000;
    end
  end

  assign coord.h_count = h_count_r;
  assign coord.v_count = v_count_r;
  assign hsync         = hsync_r;
  assign vsync         = vsync_r;
  assign video_de      = video_de_r;
  assign rgb           = rgb_r;
  assign frame_start   = frame_start_r;

endmodule
